// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: d = x - y - bin, one bit per clock (LSB first) through a
// single full-subtractor cell and a borrow flip-flop, with a start/busy/done handshake.
module serial_subtractor_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] xs_q, xs_d;
   logic [WIDTH-1:0] ys_q, ys_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic             diff_bit;
   logic             borrow_bit;
   logic [WIDTH-1:0] res_shift;

   // Full-subtractor cell working on the current LSBs and the stored borrow.
   assign diff_bit   = xs_q[0] ^ ys_q[0] ^ b_q;
   assign borrow_bit = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & b_q);
   assign res_shift  = {diff_bit, res_q[WIDTH-1:1]};

   always_comb begin
      // NOTE: every signal gets its default first so no path through the case infers a latch.
      state_d = state_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      res_d   = res_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               xs_d    = x;
               ys_d    = y;
               b_d     = bin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            res_d = res_shift;
            xs_d  = xs_q >> 1;
            ys_d  = ys_q >> 1;
            b_d   = borrow_bit;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // On the MSB step b_q is the borrow into the MSB, so overflow is borrow-in ^ borrow-out.
               state_d = S_DONE;
               cnt_d   = '0;
               d_d     = res_shift;
               bout_d  = borrow_bit;
               ovf_d   = b_q ^ borrow_bit;
               zero_d  = (res_shift == '0);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         xs_q    <= '0;
         ys_q    <= '0;
         res_q   <= '0;
         b_q     <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         res_q   <= res_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign d    = d_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed bench for serial_subtractor_8bit: expected results are queued when an
// operation is launched and compared when the done pulse appears.
module tb_serial_subtractor_8bit;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             bout;
      logic             ovf;
      logic             zero;
   } res_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] x, y;
   logic             bin;
   logic             busy, done;
   logic [WIDTH-1:0] d;
   logic             bout, ovf, zero;

   res_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   serial_subtractor_8bit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout),
      .ovf   (ovf),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic bi);
      res_t         r;
      logic [WIDTH:0] t;
      int           sa, sb, s;
      t  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
      sa = $signed(a);
      sb = $signed(b);
      s  = sa - sb - int'(bi);
      r.d    = t[WIDTH-1:0];
      r.bout = t[WIDTH];
      r.ovf  = (s < -(2 ** (WIDTH - 1))) || (s > (2 ** (WIDTH - 1)) - 1);
      r.zero = (t[WIDTH-1:0] == '0);
      return r;
   endfunction

   task automatic compare_result(input string tag);
      res_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_d"},    32'(d),    32'(e.d));
         check({tag, "_bout"}, 32'(bout), 32'(e.bout));
         check({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
         check({tag, "_zero"}, 32'(zero), 32'(e.zero));
      end
   endtask

   // Launch one operation, scramble inputs while it runs, and verify handshake and result.
   task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bi, input bit mid_start);
      int n;
      int busy_cnt;
      logic [WIDTH-1:0] d_hold;
      @(negedge clk);
      x = a; y = b; bin = bi; start = 1'b1;
      exp_q.push_back(model(a, b, bi));
      @(negedge clk);
      start = 1'b0;
      x = WIDTH'($urandom); y = WIDTH'($urandom); bin = 1'($urandom);
      n = 0;
      busy_cnt = 0;
      while (!done && n < 20) begin
         if (busy) busy_cnt++;
         if (mid_start && n == 3) begin
            start = 1'b1; x = 8'hFF; y = 8'h00;
         end
         if (mid_start && n == 4) start = 1'b0;
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_busy_cycles"}, busy_cnt, WIDTH);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      compare_result(tag);
      d_hold = d;
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_d_held"}, 32'(d), 32'(d_hold));
   endtask

   initial begin
      int n_done;
      int last_done;
      int hits;

      rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_d",    32'(d),    32'd0);
      check("reset_flags", {29'd0, bout, ovf, zero}, 32'd0);
      rst = 1'b0;

      // Main function and signed overflow cases.
      do_op("op_6b_5d", 8'h6B, 8'h5D, 1'b0, 1'b0);
      do_op("op_80_21", 8'h80, 8'h21, 1'b0, 1'b0);
      do_op("op_40_11_b", 8'h40, 8'h11, 1'b1, 1'b0);

      // Wrap-around and boundary cases.
      do_op("op_00_01", 8'h00, 8'h01, 1'b0, 1'b0);
      do_op("op_00_00_b", 8'h00, 8'h00, 1'b1, 1'b0);
      do_op("op_55_55", 8'h55, 8'h55, 1'b0, 1'b0);
      do_op("op_7f_ff", 8'h7F, 8'hFF, 1'b0, 1'b0);

      // start pulsed during RUN must be ignored.
      do_op("op_mid_start", 8'h10, 8'h01, 1'b0, 1'b1);
      hits = 0;
      repeat (12) begin
         if (busy || done) hits++;
         @(negedge clk);
      end
      check("mid_start_no_relaunch", hits, 0);

      // Reset in the middle of RUN discards the operation.
      @(negedge clk);
      x = 8'h6B; y = 8'h5D; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_d",    32'(d),    32'd0);
      repeat (2) @(negedge clk);
      check("abort_idle_busy", 32'(busy), 32'd0);
      do_op("op_after_abort", 8'h03, 8'h01, 1'b0, 1'b0);

      // start held high: done every WIDTH+2 cycles.
      @(negedge clk);
      x = 8'h09; y = 8'h04; bin = 1'b0; start = 1'b1;
      repeat (3) exp_q.push_back(model(8'h09, 8'h04, 1'b0));
      n_done = 0;
      last_done = -1;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            check("held_busy_in_done", 32'(busy), 32'd0);
            compare_result("held");
            if (last_done >= 0) check("held_period", k - last_done, WIDTH + 2);
            last_done = k;
         end
      end
      check("held_done_count", n_done, 3);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
